// File: rtl/fb_line_streamer.sv
// Framebuffer scan-out: bursts each scanline from memory into a FIFO and streams it as AXI-Stream
// video. Define FB_TESTPATTERN_EN to add a generated test-pattern source in place of memory reads.
module fb_line_streamer #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              m_axis_vid_aclk,
  input  logic              aresetn,
  input  logic              enable,
`ifdef FB_TESTPATTERN_EN
  input  logic              test_pattern,
`endif
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [11:0]       cfg_words,
  input  logic [11:0]       cfg_lines,
  input  logic [15:0]       cfg_stride,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_len,
  input  logic [31:0]       rd_data,
  input  logic              rd_data_valid,
  output logic [31:0]       m_axis_vid_tdata,
  output logic              m_axis_vid_tvalid,
  input  logic              m_axis_vid_tready,
  output logic              m_axis_vid_tlast,
  output logic              m_axis_vid_tuser,
  output logic              busy,
  output logic              frame_done
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StReq, StNext, StDrain} state_e;

  state_e            r_state, w_state_d;
  logic [11:0]       r_words, w_words_d, r_lines, w_lines_d;
  logic [11:0]       r_req_line, w_req_line_d, r_words_left, w_words_left_d;
  logic [15:0]       r_stride, w_stride_d;
  logic [ADDR_W-1:0] r_line_addr, w_line_addr_d, r_rd_addr, w_rd_addr_d;
  logic [7:0]        r_rd_len, w_rd_len_d;
  logic              r_rd_valid, w_rd_valid_d;
  logic              r_busy, w_busy_d, r_frame_done, w_frame_done_d;
  logic              r_tp, w_tp_d;

  logic [CW-1:0]     r_count, r_outstanding;
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [31:0]       r_tdata;
  logic              r_tvalid, r_tlast, r_tuser, r_tfinal, r_gen_done;
  logic [11:0]       r_out_x, r_out_y;

  logic [12:0]       w_beats;
  logic [31:0]       w_free;
  logic              w_credit_ok, w_rd_hs, w_xfer, w_avail, w_load, w_fifo_rd;
  logic              w_last_x, w_last_y, w_tp_in;
  logic [31:0]       w_pattern;

`ifdef FB_TESTPATTERN_EN
  assign w_tp_in = test_pattern;
`else
  assign w_tp_in = 1'b0;
`endif

  assign w_beats     = (r_words_left >= 12'(BURST_LEN)) ? 13'(BURST_LEN) : {1'b0, r_words_left};
  // Space not yet spoken for by data in the FIFO or data already requested.
  assign w_free      = 32'(FIFO_DEPTH) - 32'(r_count) - 32'(r_outstanding);
  assign w_credit_ok = w_free >= 32'(w_beats);
  assign w_rd_hs     = r_rd_valid & rd_ready;

  always_comb begin
    w_state_d       = r_state;
    w_words_d       = r_words;
    w_lines_d       = r_lines;
    w_stride_d      = r_stride;
    w_req_line_d    = r_req_line;
    w_words_left_d  = r_words_left;
    w_line_addr_d   = r_line_addr;
    w_rd_addr_d     = r_rd_addr;
    w_rd_len_d      = r_rd_len;
    w_rd_valid_d    = r_rd_valid;
    w_busy_d        = r_busy;
    w_tp_d          = r_tp;
    w_frame_done_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (enable) begin
          w_words_d      = cfg_words;
          w_lines_d      = cfg_lines;
          w_stride_d     = cfg_stride;
          w_line_addr_d  = cfg_base;
          w_rd_addr_d    = cfg_base;
          w_req_line_d   = '0;
          w_words_left_d = cfg_words;
          w_busy_d       = 1'b1;
          w_tp_d         = w_tp_in;
          w_state_d      = w_tp_in ? StDrain : StReq;
        end
      end
      StReq: begin
        if (!r_rd_valid) begin
          if (w_credit_ok) begin
            w_rd_valid_d = 1'b1;
            w_rd_len_d   = 8'(w_beats - 13'd1);
          end
        end else if (rd_ready) begin
          w_rd_valid_d   = 1'b0;
          w_rd_addr_d    = r_rd_addr + ADDR_W'({w_beats, 2'b00});
          w_words_left_d = r_words_left - w_beats[11:0];
          if (r_words_left == w_beats[11:0]) w_state_d = StNext;
        end
      end
      StNext: begin
        w_line_addr_d = r_line_addr + ADDR_W'(r_stride);
        w_req_line_d  = r_req_line + 12'd1;
        if (r_req_line == r_lines - 12'd1) begin
          w_state_d = StDrain;
        end else begin
          w_words_left_d = r_words;
          w_rd_addr_d    = w_line_addr_d;
          w_state_d      = StReq;
        end
      end
      StDrain: begin
        if (w_xfer && r_tfinal) begin
          w_frame_done_d = 1'b1;
          w_busy_d       = 1'b0;
          w_state_d      = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn) begin
      r_words <= '0; r_lines <= '0; r_stride <= '0; r_req_line <= '0; r_words_left <= '0;
      r_line_addr <= '0; r_rd_addr <= '0; r_rd_len <= '0; r_rd_valid <= 1'b0;
      r_busy <= 1'b0; r_frame_done <= 1'b0; r_tp <= 1'b0;
    end else begin
      r_words <= w_words_d; r_lines <= w_lines_d; r_stride <= w_stride_d;
      r_req_line <= w_req_line_d; r_words_left <= w_words_left_d;
      r_line_addr <= w_line_addr_d; r_rd_addr <= w_rd_addr_d; r_rd_len <= w_rd_len_d;
      r_rd_valid <= w_rd_valid_d; r_busy <= w_busy_d; r_frame_done <= w_frame_done_d;
      r_tp <= w_tp_d;
    end
  end

  assign w_xfer    = r_tvalid & m_axis_vid_tready;
  assign w_avail   = r_tp ? (r_busy & ~r_gen_done) : (r_count != '0);
  assign w_load    = w_avail & (~r_tvalid | m_axis_vid_tready);
  assign w_fifo_rd = w_load & ~r_tp;
  // out_x/out_y track the word being loaded into the output register.
  assign w_last_x  = r_out_x == r_words - 12'd1;
  assign w_last_y  = r_out_y == r_lines - 12'd1;
  assign w_pattern = {8'h00, r_out_y[7:0], r_out_x[7:0], r_out_x[7:0] ^ r_out_y[7:0]};

  always_ff @(posedge m_axis_vid_aclk) begin
    if (rd_data_valid) r_mem[r_wptr] <= rd_data;
  end

  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn) begin
      r_wptr <= '0; r_rptr <= '0; r_count <= '0; r_outstanding <= '0;
      r_tdata <= '0; r_tvalid <= 1'b0; r_tlast <= 1'b0; r_tuser <= 1'b0; r_tfinal <= 1'b0;
      r_gen_done <= 1'b0; r_out_x <= '0; r_out_y <= '0;
    end else begin
      if (rd_data_valid) r_wptr <= r_wptr + PW'(1);
      if (w_fifo_rd)     r_rptr <= r_rptr + PW'(1);
      r_count       <= r_count + CW'(rd_data_valid) - CW'(w_fifo_rd);
      r_outstanding <= r_outstanding + (w_rd_hs ? CW'(w_beats) : '0) - CW'(rd_data_valid);
      if (w_load) begin
        r_tvalid <= 1'b1;
        r_tdata  <= r_tp ? w_pattern : r_mem[r_rptr];
        r_tlast  <= w_last_x;
        r_tuser  <= (r_out_x == '0) && (r_out_y == '0);
        r_tfinal <= w_last_x & w_last_y;
        if (w_last_x) begin
          r_out_x <= '0;
          r_out_y <= w_last_y ? '0 : r_out_y + 12'd1;
        end else begin
          r_out_x <= r_out_x + 12'd1;
        end
        if (w_last_x && w_last_y) r_gen_done <= 1'b1;
      end else if (w_xfer) begin
        r_tvalid <= 1'b0; r_tlast <= 1'b0; r_tuser <= 1'b0; r_tfinal <= 1'b0;
      end
      if (r_state == StIdle && enable) r_gen_done <= 1'b0;
    end
  end

  assign rd_valid          = r_rd_valid;
  assign rd_addr           = r_rd_addr;
  assign rd_len            = r_rd_len;
  assign m_axis_vid_tdata  = r_tdata;
  assign m_axis_vid_tvalid = r_tvalid;
  assign m_axis_vid_tlast  = r_tlast;
  assign m_axis_vid_tuser  = r_tuser;
  assign busy              = r_busy;
  assign frame_done        = r_frame_done;
endmodule

// File: tb/tb_fb_line_streamer.sv
// Bench for fb_line_streamer: a table of frame configurations driven through a random-latency
// memory model and random backpressure, checked against a line/burst reference model.
`timescale 1ns/1ps
module tb_fb_line_streamer;
  localparam int FifoDepth = 64;
  localparam int BurstLen  = 16;

  logic        clk = 1'b0;
  logic        aresetn, enable;
  logic [31:0] cfg_base;
  logic [11:0] cfg_words, cfg_lines;
  logic [15:0] cfg_stride;
  logic        rd_valid, rd_ready, rd_data_valid;
  logic [31:0] rd_addr, rd_data;
  logic [7:0]  rd_len;
  logic [31:0] tdata;
  logic        tvalid, tready, tlast, tuser, busy, frame_done;
`ifdef FB_TESTPATTERN_EN
  logic        test_pattern;
`endif

  always #5 clk = ~clk;

  fb_line_streamer #(.FIFO_DEPTH(FifoDepth), .BURST_LEN(BurstLen), .ADDR_W(32)) dut (
    .m_axis_vid_aclk(clk), .aresetn(aresetn), .enable(enable),
`ifdef FB_TESTPATTERN_EN
    .test_pattern(test_pattern),
`endif
    .cfg_base(cfg_base), .cfg_words(cfg_words), .cfg_lines(cfg_lines), .cfg_stride(cfg_stride),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .m_axis_vid_tdata(tdata), .m_axis_vid_tvalid(tvalid), .m_axis_vid_tready(tready),
    .m_axis_vid_tlast(tlast), .m_axis_vid_tuser(tuser), .busy(busy), .frame_done(frame_done)
  );

  typedef struct { logic [31:0] data; logic user; logic last; } word_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; } req_t;
  typedef struct { logic [31:0] addr; int due; } beat_t;
  typedef struct {
    int words; int lines; logic [31:0] stride; logic [31:0] base;
    bit rnd_ready; bit rnd_mem; bit hold_en;
    int nreq; int nbeats; int ntlast;
  } vec_t;

  word_t exp_q[$];
  req_t  req_q[$];
  beat_t mem_q[$];
  int    n_vec = 0, n_err = 0, cyc = 0;
  int    fd_cnt, nreq_seen, nxfer, ntlast, ntuser, req_beats, max_occ;
  bit    rand_ready, rand_mem, stalled, tp_mode;
  word_t held;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got an unexpected transfer, expected none", name);
  endtask

  // Expected stream and requests from the frame geometry alone.
  task automatic build_model(int words, int lines, logic [31:0] stride, logic [31:0] base);
    logic [31:0] line_addr;
    word_t w;
    req_t  r;
    int    n;
    exp_q.delete();
    req_q.delete();
    line_addr = base;
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < words; x++) begin
        w.data = tp_mode ? {8'h00, 8'(y), 8'(x), 8'(x) ^ 8'(y)} : line_addr + 32'(4 * x);
        w.user = (x == 0 && y == 0);
        w.last = (x == words - 1);
        exp_q.push_back(w);
      end
      if (!tp_mode) begin
        for (int x = 0; x < words; x += BurstLen) begin
          n = (words - x < BurstLen) ? words - x : BurstLen;
          r.addr = line_addr + 32'(4 * x);
          r.len  = 8'(n - 1);
          req_q.push_back(r);
        end
      end
      line_addr = line_addr + stride;
    end
  endtask

  // One clock: check/drive at the falling edge, handshakes take effect at the next rising edge.
  task automatic tick();
    word_t e;
    req_t  r;
    beat_t b;
    int    lat;
    @(negedge clk);
    cyc++;
    if (stalled)
      check("stall_hold", {tvalid, tdata, tuser, tlast}, {1'b1, held.data, held.user, held.last});
    tready   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    rd_ready = rand_mem ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      rd_data_valid = 1'b1;
      rd_data       = mem_q[0].addr;
      void'(mem_q.pop_front());
    end else begin
      rd_data_valid = 1'b0;
      rd_data       = $urandom();
    end
    if (rd_valid && rd_ready) begin
      nreq_seen++;
      if (req_q.size() == 0) unexpected("extra_req");
      else begin
        r = req_q.pop_front();
        check("req_addr_len", {rd_addr, rd_len}, {r.addr, r.len});
      end
      lat = rand_mem ? int'($urandom_range(1, 20)) : 1;
      for (int i = 0; i <= int'(rd_len); i++) begin
        b.addr = rd_addr + 32'(4 * i);
        b.due  = cyc + lat;
        mem_q.push_back(b);
      end
      req_beats += int'(rd_len) + 1;
    end
    if (tvalid && tready) begin
      nxfer++;
      ntlast += int'(tlast);
      ntuser += int'(tuser);
      if (exp_q.size() == 0) unexpected("extra_word");
      else begin
        e = exp_q.pop_front();
        check("word", {tdata, tuser, tlast}, {e.data, e.user, e.last});
      end
      stalled = 1'b0;
    end else if (tvalid) begin
      stalled = 1'b1;
      held.data = tdata; held.user = tuser; held.last = tlast;
    end else begin
      stalled = 1'b0;
    end
    if (frame_done) fd_cnt++;
    if (req_beats - nxfer > max_occ) max_occ = req_beats - nxfer;
  endtask

  task automatic start_frame(vec_t v);
    rand_ready = v.rnd_ready;
    rand_mem   = v.rnd_mem;
    build_model(v.words, v.lines, v.stride, v.base);
    fd_cnt = 0; nreq_seen = 0; nxfer = 0; ntlast = 0; ntuser = 0; req_beats = 0; max_occ = 0;
    cfg_words  = 12'(v.words);
    cfg_lines  = 12'(v.lines);
    cfg_stride = v.stride[15:0];
    cfg_base   = v.base;
    enable     = 1'b1;
  endtask

  task automatic run_frame(vec_t v);
    bit dropped;
    int budget;
    start_frame(v);
    dropped = 1'b0;
    budget  = 0;
    while (fd_cnt == 0 && budget < 30000) begin
      tick();
      budget++;
      if (!dropped && (v.hold_en ? (ntlast >= 1) : busy)) begin
        enable     = 1'b0;
        dropped    = 1'b1;
        // Mid-frame config changes must not disturb the running frame.
        cfg_words  = 12'($urandom_range(1, 4095));
        cfg_lines  = 12'($urandom_range(1, 4095));
        cfg_stride = 16'($urandom());
        cfg_base   = $urandom() & 32'hFFFF_FFFC;
      end
    end
    for (int i = 0; i < 12; i++) tick();
    check("frame_done_pulses", 64'(fd_cnt), 64'(1));
    check("req_count", 64'(nreq_seen), 64'(v.nreq));
    check("beat_count", 64'(nxfer), 64'(v.nbeats));
    check("tlast_count", 64'(ntlast), 64'(v.ntlast));
    check("tuser_count", 64'(ntuser), 64'(1));
    check("words_missing", 64'(exp_q.size()), 64'(0));
    check("reqs_missing", 64'(req_q.size()), 64'(0));
    check("busy_after", {63'd0, busy}, 64'(0));
    check("occupancy_ok", 64'(max_occ <= FifoDepth + 1), 64'(1));
  endtask

  initial begin
    vec_t vecs[7];
    vec_t v;
    vecs[0] = '{4,   2, 32'h1000, 32'h0010_0000, 1'b0, 1'b0, 1'b0, 2,  8,   2};
    vecs[1] = '{40,  1, 32'h40,   32'h0020_0000, 1'b0, 1'b0, 1'b0, 3,  40,  1};
    vecs[2] = '{200, 3, 32'h400,  32'h0030_0000, 1'b1, 1'b1, 1'b0, 39, 600, 3};
    vecs[3] = '{10,  4, 32'h80,   32'h0040_0000, 1'b0, 1'b0, 1'b1, 4,  40,  4};
    vecs[4] = '{1,   5, 32'h8,    32'h0050_0000, 1'b1, 1'b0, 1'b0, 5,  5,   5};
    vecs[5] = '{17,  2, 32'h100,  32'hFFFF_FF00, 1'b0, 1'b1, 1'b0, 4,  34,  2};
    vecs[6] = '{16,  4, 32'h0,    32'h0070_0000, 1'b1, 1'b1, 1'b0, 4,  64,  4};

    tp_mode = 1'b0; stalled = 1'b0; rand_ready = 1'b0; rand_mem = 1'b0;
`ifdef FB_TESTPATTERN_EN
    test_pattern = 1'b0;
`endif
    aresetn = 1'b0; enable = 1'b0; rd_ready = 1'b0; rd_data_valid = 1'b0; rd_data = '0;
    tready = 1'b0; cfg_base = '0; cfg_words = '0; cfg_lines = '0; cfg_stride = '0;
    repeat (3) @(negedge clk);
    check("rst_rd_valid", {63'd0, rd_valid}, 64'(0));
    check("rst_tvalid", {63'd0, tvalid}, 64'(0));
    check("rst_tlast_tuser", {62'd0, tlast, tuser}, 64'(0));
    check("rst_busy_done", {62'd0, busy, frame_done}, 64'(0));
    check("rst_rd_addr_len", {24'd0, rd_addr, rd_len}, 64'(0));
    aresetn = 1'b1;

    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    // Reset during line 2 of a frame, then a fresh frame from the top.
    v = '{8, 4, 32'h200, 32'h0060_0000, 1'b1, 1'b1, 1'b0, 4, 32, 4};
    start_frame(v);
    for (int i = 0; i < 5000 && nxfer < 18; i++) tick();
    check("reached_line2", 64'(nxfer >= 18), 64'(1));
    aresetn = 1'b0; rd_data_valid = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    check("midrst_tvalid", {63'd0, tvalid}, 64'(0));
    check("midrst_rd_valid", {63'd0, rd_valid}, 64'(0));
    check("midrst_busy", {63'd0, busy}, 64'(0));
    mem_q.delete();
    stalled = 1'b0;
    aresetn = 1'b1;
    run_frame(v);

`ifdef FB_TESTPATTERN_EN
    tp_mode = 1'b1;
    test_pattern = 1'b1;
    v = '{3, 2, 32'h100, 32'h0080_0000, 1'b1, 1'b0, 1'b0, 0, 6, 2};
    run_frame(v);
    test_pattern = 1'b0;
    tp_mode = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fb_line_streamer.md
Name: fb_line_streamer

Overview:
- Framebuffer scan-out source feeding the video output stage's AXI-Stream input (`m_axis_vid_*`).
- Fetches each scanline from memory in bursts over a simple read request/response channel and buffers it in a FIFO.
- Emits 32-bit pixel words with `tuser` on the first word of each frame and `tlast` on the last word of each line.
- Config is latched per frame, so mode changes take effect only at frame boundaries.

Parameters:
- FIFO_DEPTH, 64, data FIFO entries (32-bit); power of two, >= 2*BURST_LEN.
- BURST_LEN, 16, maximum beats per read request; power of two, 1..256.
- ADDR_W, 32, byte-address width.

Ports:
- m_axis_vid_aclk  in  1  clock
- aresetn  in  1  reset; synchronous, active-low, sampled on m_axis_vid_aclk
- enable  in  1  run frames continuously while high
- cfg_base  in  ADDR_W  frame base byte address, 4-byte aligned
- cfg_words  in  12  32-bit words per line, 1..4095
- cfg_lines  in  12  lines per frame, 1..4095
- cfg_stride  in  16  byte pitch between line starts
- rd_valid  out  1  read request valid
- rd_ready  in  1  read request accepted
- rd_addr  out  ADDR_W  burst start byte address
- rd_len  out  8  beats minus one
- rd_data  in  32  read data beat
- rd_data_valid  in  1  data beat valid; always accepted
- m_axis_vid_tdata  out  32  pixel word
- m_axis_vid_tvalid  out  1  stream valid
- m_axis_vid_tready  in  1  stream ready
- m_axis_vid_tlast  out  1  last word of line
- m_axis_vid_tuser  out  1  first word of frame
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last word of a frame is transferred

Behaviour:
- Reset values: rd_valid, m_axis_vid_tvalid, tlast, tuser, busy and frame_done are 0; rd_addr and rd_len are 0; FIFO is empty; all counters are 0; request FSM is in IDLE.
- Request FSM states: IDLE, REQ, NEXT, DRAIN.
  - IDLE: when enable=1, latch all cfg_* inputs, set line_addr=cfg_base, req_line=0, busy=1, go to REQ.
  - REQ: beats = min(BURST_LEN, words_left).
    - Present rd_valid only when (FIFO_DEPTH - fifo_count - outstanding) >= beats.
    - rd_valid, rd_addr and rd_len hold stable until rd_ready.
    - On handshake: outstanding += beats, rd_addr += beats*4, words_left -= beats.
    - If words_left reaches 0, go to NEXT.
  - NEXT: line_addr += cfg_stride (wraps at ADDR_W), req_line += 1.
    - If req_line == lines-1, go to DRAIN; else words_left = words and go to REQ.
  - DRAIN: wait for the output side's last `tlast` of the frame, pulse frame_done, go to IDLE. IDLE re-latches config and restarts the same cycle if enable is still 1.
- Data side: each rd_data_valid beat is written to the FIFO and decrements outstanding. Overflow is impossible by the credit rule; the bench asserts it never occurs.
  - If a write and a read happen in the same cycle, fifo_count is unchanged.
- Output side:
  - tdata, tlast and tuser are registered from the FIFO head.
  - tvalid rises one cycle after the FIFO becomes non-empty.
  - While tvalid=1 and tready=0, tdata, tlast and tuser hold stable.
  - Position counters out_x/out_y advance on each handshake.
  - tlast=1 when out_x==words-1; tuser=1 when out_x==0 and out_y==0.
  - Gap-free streaming at 1 word/clock is required when memory keeps up.
- enable deasserted mid-frame: the current frame completes fully (all lines, final tlast). No new frame starts.
- cfg_* changes mid-frame are ignored until the next IDLE latch.
- Reset mid-operation: all state returns to reset values on the next clock. The memory subsystem is reset by the same aresetn, so no stale responses arrive.
- Latency: first tvalid occurs no earlier than 2 cycles after the first rd_data_valid beat.

Optional Feature:
- FB_TESTPATTERN_EN defined: adds input `test_pattern` (1 bit, latched in IDLE).
  - When latched high, no reads are issued.
  - Output words are generated directly: tdata = {8'h00, out_y[7:0], out_x[7:0], out_x[7:0] ^ out_y[7:0]}.
  - Same tuser/tlast/frame timing and backpressure rules apply.
- Undefined: port absent; memory path only.

Test Plan:
- words=4, lines=2, stride=0x1000, base=0x100000, tready=1, zero-latency memory -> two requests: (0x100000, len 3), (0x101000, len 3). Eight beats; tuser on beat 0, tlast on beats 3 and 7; frame_done pulses once.
- words=40, lines=1 -> requests len 15 @base, len 15 @base+64, len 7 @base+128; 40 beats; single tlast on beat 39.
- words=200, lines=3, random tready (50%), random rd_ready and memory latency 1-20 -> 600 words in address order, none dropped or duplicated; tdata stable under stall; fifo_count+outstanding <= 64 at all times.
- enable=1 then deasserted at line 1 of lines=4 -> all 4 lines emitted; frame_done once; no further rd_valid or tuser.
- aresetn=0 asserted during line 2 of a frame -> next cycle tvalid=0, rd_valid=0, busy=0. On release with enable=1, a fresh frame starts with tuser on the first word.
- FB_TESTPATTERN_EN, test_pattern=1, words=3, lines=2 -> rd_valid never asserted; tdata sequence 0x000000, 0x000101, 0x000202, 0x010001, 0x010100, 0x010203.
